// File: rtl/hazard_sched_ctrl_if.sv
// Hazard-scheduler bundle: hazard-detection inputs from the pipeline, stall/flush
// enables and statistics back to it. master = pipeline side, slave = scheduler.
interface hazard_sched_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PERF_W = 32
);
  logic [REG_AW-1:0] RsD;
  logic [REG_AW-1:0] RtD;
  logic [REG_AW-1:0] RtE;
  logic              MemToRegE;
  logic              PCSrcE;
  logic              MemReqM;
  logic              MemReadyM;
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              StallE;
  logic              FlushE;
  logic              StallM;
  logic              Halted;
  logic [PERF_W-1:0] LdUseCnt;
  logic [PERF_W-1:0] MemWaitCnt;
  logic [PERF_W-1:0] FlushCnt;

  modport master (
    output RsD, RtD, RtE, MemToRegE, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, FlushD, StallE, FlushE, StallM, Halted,
    input  LdUseCnt, MemWaitCnt, FlushCnt
  );

  modport slave (
    input  RsD, RtD, RtE, MemToRegE, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, FlushD, StallE, FlushE, StallM, Halted,
    output LdUseCnt, MemWaitCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_sched_ctrl.sv
// Pipeline hazard scheduler: load-use bubbles, taken-branch flushes, memory-wait freezes
// and a memory-wait watchdog. Define STALL_PERF_CNT_EN to build the hazard statistics counters.
module hazard_sched_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PERF_W      = 32
) (
  input logic              CLK,
  input logic              RST,
  hazard_sched_ctrl_if.slave hz
);

  localparam bit             TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W:0] TIMEOUT_V  = (CNT_W+1)'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

  state_t           state;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W:0]   cntNext;
  logic             memWait;
  logic             ldUse;

  assign memWait = hz.MemReqM & ~hz.MemReadyM;
  assign ldUse   = hz.MemToRegE & (hz.RtE != REG_AW'(0)) &
                   ((hz.RtE == hz.RsD) | (hz.RtE == hz.RtD));
  assign cntNext = {1'b0, waitCnt} + (CNT_W+1)'(1);

  // Stall/flush enables act in the same cycle; everything is forced low during reset.
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.FlushD = 1'b0;
    hz.StallE = 1'b0;
    hz.FlushE = 1'b0;
    hz.StallM = 1'b0;
    hz.Halted = 1'b0;
    if (!RST) begin
      if (state == HALT) begin
        {hz.StallF, hz.StallD, hz.StallE, hz.StallM} = 4'b1111;
        hz.Halted = 1'b1;
      end else if (memWait) begin
        {hz.StallF, hz.StallD, hz.StallE, hz.StallM} = 4'b1111;
      end else if (hz.PCSrcE) begin
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (ldUse) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
    end
  end

  // Freeze tracking; the counter saturates instead of wrapping when the watchdog is off.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (memWait) begin
            state   <= (TIMEOUT_EN && TIMEOUT_V == (CNT_W+1)'(1)) ? HALT : MEMWAIT;
            waitCnt <= CNT_W'(1);
          end
        end
        MEMWAIT: begin
          if (memWait) begin
            if (TIMEOUT_EN && cntNext == TIMEOUT_V) state <= HALT;
            if (!cntNext[CNT_W]) waitCnt <= cntNext[CNT_W-1:0];
          end else begin
            state   <= RUN;
            waitCnt <= '0;
          end
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic ldUseEv;
  logic memWaitEv;
  logic flushEv;

  assign memWaitEv = (state != HALT) & memWait;
  assign flushEv   = (state != HALT) & ~memWait & hz.PCSrcE;
  assign ldUseEv   = (state != HALT) & ~memWait & ~hz.PCSrcE & ldUse;

  // Event counters wrap naturally and hold while halted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hz.LdUseCnt   <= '0;
      hz.MemWaitCnt <= '0;
      hz.FlushCnt   <= '0;
    end else begin
      if (ldUseEv)   hz.LdUseCnt   <= hz.LdUseCnt + PERF_W'(1);
      if (memWaitEv) hz.MemWaitCnt <= hz.MemWaitCnt + PERF_W'(1);
      if (flushEv)   hz.FlushCnt   <= hz.FlushCnt + PERF_W'(1);
    end
  end
`else
  assign hz.LdUseCnt   = PERF_W'(0);
  assign hz.MemWaitCnt = PERF_W'(0);
  assign hz.FlushCnt   = PERF_W'(0);
`endif

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Directed bench for hazard_sched_ctrl (watchdog timeout 5); counter checks follow STALL_PERF_CNT_EN.
module tb_hazard_sched_ctrl;

`ifdef STALL_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  // {StallF, StallD, FlushD, StallE, FlushE, StallM, Halted}
  localparam logic [6:0] NONE   = 7'b0000000;
  localparam logic [6:0] LDUSE  = 7'b1100100;
  localparam logic [6:0] BRANCH = 7'b0010100;
  localparam logic [6:0] FREEZE = 7'b1101010;
  localparam logic [6:0] HALTV  = 7'b1101011;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   nCmp = 0;
  int   nBad = 0;
  logic [31:0] expLd = 0;
  logic [31:0] expMw = 0;
  logic [31:0] expFl = 0;

  hazard_sched_ctrl_if #(.REG_AW(5), .PERF_W(32)) hz ();

  hazard_sched_ctrl #(
    .REG_AW(5), .MEM_TIMEOUT(5), .CNT_W(8), .PERF_W(32)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .hz (hz.slave)
  );

  always #5 CLK = ~CLK;

  wire [6:0]  outs = {hz.StallF, hz.StallD, hz.FlushD, hz.StallE, hz.FlushE, hz.StallM, hz.Halted};
  wire [95:0] cnts = {hz.LdUseCnt, hz.MemWaitCnt, hz.FlushCnt};
  wire [95:0] cntWant = PERF_ON ? {expLd, expMw, expFl} : 96'd0;

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rte,
                       input logic m2r, input logic pcs, input logic req, input logic rdy);
    hz.RsD = rs; hz.RtD = rt; hz.RtE = rte;
    hz.MemToRegE = m2r; hz.PCSrcE = pcs; hz.MemReqM = req; hz.MemReadyM = rdy;
  endtask

  task automatic test_reset;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge CLK);
    #1 nCmp++;
    if (outs !== NONE) begin nBad++; $display("FAIL reset_outs: got %b want %b", outs, NONE); end
    nCmp++;
    if (cnts !== cntWant) begin nBad++; $display("FAIL reset_cnts: got %h want %h", cnts, cntWant); end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
  endtask

  task automatic test_load_use;
    @(negedge CLK); drive(5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 nCmp++;
    if (outs !== LDUSE) begin nBad++; $display("FAIL lduse_rs: got %b want %b", outs, LDUSE); end
    expLd = expLd + 1;
    @(negedge CLK); drive(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 nCmp++;
    if (outs !== NONE) begin nBad++; $display("FAIL lduse_after: got %b want %b", outs, NONE); end
    nCmp++;
    if (cnts !== cntWant) begin nBad++; $display("FAIL lduse_cnt: got %h want %h", cnts, cntWant); end
    @(negedge CLK); drive(5'd5, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 nCmp++;
    if (outs !== LDUSE) begin nBad++; $display("FAIL lduse_rt: got %b want %b", outs, LDUSE); end
    expLd = expLd + 1;
    @(negedge CLK); drive(5'd5, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 nCmp++;
    if (outs !== NONE) begin nBad++; $display("FAIL lduse_nomatch: got %b want %b", outs, NONE); end
    @(negedge CLK); drive(5'd5, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 nCmp++;
    if (outs !== NONE) begin nBad++; $display("FAIL lduse_noload: got %b want %b", outs, NONE); end
  endtask

  task automatic test_branch;
    @(negedge CLK); drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 nCmp++;
    if (outs !== BRANCH) begin nBad++; $display("FAIL branch_wins: got %b want %b", outs, BRANCH); end
    expFl = expFl + 1;
    @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 nCmp++;
    if (outs !== NONE) begin nBad++; $display("FAIL branch_after: got %b want %b", outs, NONE); end
    nCmp++;
    if (cnts !== cntWant) begin nBad++; $display("FAIL branch_cnt: got %h want %h", cnts, cntWant); end
  endtask

  task automatic test_mem_wait;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (i == 1) drive(5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      else        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1 nCmp++;
      if (outs !== FREEZE) begin nBad++; $display("FAIL memwait_c%0d: got %b want %b", i, outs, FREEZE); end
      expMw = expMw + 1;
    end
    @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 nCmp++;
    if (outs !== NONE) begin nBad++; $display("FAIL memwait_ready: got %b want %b", outs, NONE); end
    @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 nCmp++;
    if (cnts !== cntWant) begin nBad++; $display("FAIL memwait_cnt: got %h want %h", cnts, cntWant); end
  endtask

  task automatic test_deferred_branch;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      #1 nCmp++;
      if (outs !== FREEZE) begin nBad++; $display("FAIL defer_freeze%0d: got %b want %b", i, outs, FREEZE); end
      expMw = expMw + 1;
    end
    @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1 nCmp++;
    if (outs !== BRANCH) begin nBad++; $display("FAIL defer_ready: got %b want %b", outs, BRANCH); end
    expFl = expFl + 1;
    @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 nCmp++;
    if (cnts !== cntWant) begin nBad++; $display("FAIL defer_cnt: got %h want %h", cnts, cntWant); end
  endtask

  task automatic test_zero_reg;
    @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 nCmp++;
    if (outs !== NONE) begin nBad++; $display("FAIL zero_reg: got %b want %b", outs, NONE); end
    @(negedge CLK); drive(5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 nCmp++;
    if (outs !== NONE) begin nBad++; $display("FAIL zero_rt: got %b want %b", outs, NONE); end
  endtask

  task automatic test_watchdog;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1 nCmp++;
      if (outs !== FREEZE) begin nBad++; $display("FAIL wdog_pre%0d: got %b want %b", i, outs, FREEZE); end
      expMw = expMw + 1;
    end
    @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 nCmp++;
    if (outs !== HALTV) begin nBad++; $display("FAIL wdog_halt: got %b want %b", outs, HALTV); end
    @(negedge CLK); drive(5'd2, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    #1 nCmp++;
    if (outs !== HALTV) begin nBad++; $display("FAIL wdog_sticky: got %b want %b", outs, HALTV); end
    @(negedge CLK);
    #1 nCmp++;
    if (cnts !== cntWant) begin nBad++; $display("FAIL wdog_cnt_frozen: got %h want %h", cnts, cntWant); end
    RST = 1'b1;
    expLd = 0; expMw = 0; expFl = 0;
    #1 nCmp++;
    if (outs !== NONE) begin nBad++; $display("FAIL wdog_rst_outs: got %b want %b", outs, NONE); end
    nCmp++;
    if (cnts !== cntWant) begin nBad++; $display("FAIL wdog_rst_cnt: got %h want %h", cnts, cntWant); end
    @(negedge CLK); RST = 1'b0; drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    #1 nCmp++;
    if (outs !== NONE) begin nBad++; $display("FAIL wdog_resume: got %b want %b", outs, NONE); end
  endtask

  task automatic test_back_to_back;
    @(negedge CLK); drive(5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 nCmp++;
    if (outs !== LDUSE) begin nBad++; $display("FAIL b2b_lduse: got %b want %b", outs, LDUSE); end
    @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 nCmp++;
    if (outs !== BRANCH) begin nBad++; $display("FAIL b2b_branch: got %b want %b", outs, BRANCH); end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1 nCmp++;
      if (outs !== FREEZE) begin nBad++; $display("FAIL b2b_freeze%0d: got %b want %b", i, outs, FREEZE); end
    end
    @(negedge CLK);
    RST = 1'b1;
    expLd = 0; expMw = 0; expFl = 0;
    #1 nCmp++;
    if (outs !== NONE) begin nBad++; $display("FAIL b2b_rst_outs: got %b want %b", outs, NONE); end
    nCmp++;
    if (cnts !== cntWant) begin nBad++; $display("FAIL b2b_rst_cnt: got %h want %h", cnts, cntWant); end
    @(negedge CLK); RST = 1'b0;
    // Four fresh wait cycles must stay below the timeout of 5.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      #1 nCmp++;
      if (outs !== FREEZE) begin nBad++; $display("FAIL b2b_refreeze%0d: got %b want %b", i, outs, FREEZE); end
      expMw = expMw + 1;
    end
    @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 nCmp++;
    if (outs !== NONE) begin nBad++; $display("FAIL b2b_ready: got %b want %b", outs, NONE); end
    @(negedge CLK); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 nCmp++;
    if (cnts !== cntWant) begin nBad++; $display("FAIL b2b_cnt: got %h want %h", cnts, cntWant); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_deferred_branch();
    test_zero_reg();
    test_watchdog();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
